// File: rtl/decoder_rr_arbiter_pkg.sv
// rtl/decoder_rr_arbiter_pkg.sv - shared types for the round-robin grant arbiter
package decoder_rr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/decoder_rr_arbiter_decoder.sv
// rtl/decoder_rr_arbiter_decoder.sv - enabled binary-to-one-hot decoder
module decoder_rr_arbiter_decoder #(
  parameter int IP_WIDTH = 2
) (
  input  logic                     en,
  input  logic [IP_WIDTH-1:0]      a,
  output logic [(1<<IP_WIDTH)-1:0] op
);

  always_comb begin
    op = '0;
    if (en) op[a] = 1'b1;
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// rtl/decoder_rr_arbiter.sv - round-robin arbiter driving a one-hot grant through the decoder
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int IP_WIDTH = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [(1<<IP_WIDTH)-1:0] req,
  output logic [(1<<IP_WIDTH)-1:0] gnt,
  output logic [IP_WIDTH-1:0]      gnt_idx,
  output logic                     gnt_valid
);

  localparam int N         = 1 << IP_WIDTH;
  localparam int HW        = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_e          state, state_n;
  logic [IP_WIDTH-1:0] idx_n, last_ptr, last_ptr_n;
  logic [HW-1:0]       hold_cnt, hold_cnt_n;
  logic                release_now;
  logic                pick_found;
  logic [IP_WIDTH-1:0] pick_idx, pick_base;

  // First set bit of r scanning base, base+1, ... modulo N
  function automatic logic [IP_WIDTH:0] circ_pick(input logic [N-1:0] r,
                                                  input logic [IP_WIDTH-1:0] base);
    logic                found;
    logic [IP_WIDTH-1:0] sel, cand;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      cand = base + IP_WIDTH'(i);
      if (!found && r[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    return {found, sel};
  endfunction

  // Owner is scanned last, so any other requester wins the handover
  assign pick_base = (state == ARB_GRANT) ? gnt_idx + 1'b1 : last_ptr + 1'b1;
  assign {pick_found, pick_idx} = circ_pick(req, pick_base);

  assign release_now = !req[gnt_idx] ||
                       ((MAX_HOLD != 0) && (hold_cnt == HW'(HOLD_LAST)));

  always_comb begin
    state_n    = state;
    idx_n      = gnt_idx;
    last_ptr_n = last_ptr;
    hold_cnt_n = hold_cnt;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_n    = ARB_GRANT;
          idx_n      = pick_idx;
          hold_cnt_n = '0;
        end
      end
      ARB_GRANT: begin
        if (release_now) begin
          last_ptr_n = gnt_idx;
          hold_cnt_n = '0;
          if (pick_found) begin
            idx_n = pick_idx;
          end else begin
            state_n = ARB_IDLE;
          end
        end else if (MAX_HOLD != 0) begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      gnt_idx  <= '0;
      last_ptr <= IP_WIDTH'(N - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt_idx  <= idx_n;
      last_ptr <= last_ptr_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  assign gnt_valid = (state == ARB_GRANT);

  decoder_rr_arbiter_decoder #(
    .IP_WIDTH(IP_WIDTH)
  ) u_decoder (
    .en(gnt_valid),
    .a (gnt_idx),
    .op(gnt)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb/tb_decoder_rr_arbiter.sv - directed checks of the round-robin grant arbiter
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst, rst_u;
  logic [3:0] req, req_u;
  logic [3:0] gnt, gnt_u;
  logic [1:0] gnt_idx, gnt_idx_u;
  logic       gnt_valid, gnt_valid_u;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decoder_rr_arbiter #(.IP_WIDTH(2), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  decoder_rr_arbiter #(.IP_WIDTH(2), .MAX_HOLD(0)) dut_unl (
    .clk(clk), .rst(rst_u), .req(req_u),
    .gnt(gnt_u), .gnt_idx(gnt_idx_u), .gnt_valid(gnt_valid_u)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    rst = 1'b1;
    req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      step();
      exp = 7'b0_00_0000;
      vectors++;
      if ({gnt_valid, gnt_idx, gnt} !== exp) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got=%b want=%b", c, {gnt_valid, gnt_idx, gnt}, exp);
      end
    end
    rst = 1'b0;
    step();
    exp = 7'b1_00_0001;
    vectors++;
    if ({gnt_valid, gnt_idx, gnt} !== exp) begin
      miscompares++;
      $display("FAIL reset_first_grant got=%b want=%b", {gnt_valid, gnt_idx, gnt}, exp);
    end
    req = 4'b0000;
    step();
    exp = 7'b0_00_0000;
    vectors++;
    if ({gnt_valid, gnt_idx, gnt} !== exp) begin
      miscompares++;
      $display("FAIL reset_drop got=%b want=%b", {gnt_valid, gnt_idx, gnt}, exp);
    end
  endtask

  task automatic test_single();
    logic [6:0] exp;
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      exp = 7'b1_10_0100;
      vectors++;
      if ({gnt_valid, gnt_idx, gnt} !== exp) begin
        miscompares++;
        $display("FAIL single_grant cyc=%0d got=%b want=%b", c, {gnt_valid, gnt_idx, gnt}, exp);
      end
    end
    req = 4'b0000;
    step();
    exp = 7'b0_10_0000;
    vectors++;
    if ({gnt_valid, gnt} !== {exp[6], exp[3:0]}) begin
      miscompares++;
      $display("FAIL single_drop got=%b want=%b", {gnt_valid, gnt}, {exp[6], exp[3:0]});
    end
  endtask

  task automatic test_rotation();
    logic [6:0] exp;
    logic [1:0] own;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      step();
      own = 2'((c / 4) % 4);
      exp = {1'b1, own, 4'(1 << own)};
      vectors++;
      if ({gnt_valid, gnt_idx, gnt} !== exp) begin
        miscompares++;
        $display("FAIL rotation cyc=%0d got=%b want=%b", c, {gnt_valid, gnt_idx, gnt}, exp);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_handover();
    logic [6:0] exp;
    req = 4'b1010;
    step();
    exp = 7'b1_01_0010;
    vectors++;
    if ({gnt_valid, gnt_idx, gnt} !== exp) begin
      miscompares++;
      $display("FAIL handover_owner1 got=%b want=%b", {gnt_valid, gnt_idx, gnt}, exp);
    end
    req = 4'b1000;
    step();
    exp = 7'b1_11_1000;
    vectors++;
    if ({gnt_valid, gnt_idx, gnt} !== exp) begin
      miscompares++;
      $display("FAIL handover_to3 got=%b want=%b", {gnt_valid, gnt_idx, gnt}, exp);
    end
    req = 4'b0000;
    step();
    vectors++;
    if (gnt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL handover_idle got=%b want=0", gnt_valid);
    end
  endtask

  task automatic test_sole_timeout();
    logic [6:0] exp;
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      step();
      exp = 7'b1_00_0001;
      vectors++;
      if ({gnt_valid, gnt_idx, gnt} !== exp) begin
        miscompares++;
        $display("FAIL sole_timeout cyc=%0d got=%b want=%b", c, {gnt_valid, gnt_idx, gnt}, exp);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_unlimited_reset();
    logic [6:0] exp;
    rst_u = 1'b1;
    step();
    rst_u = 1'b0;
    req_u = 4'b1111;
    for (int c = 0; c < 50; c++) begin
      step();
      exp = 7'b1_00_0001;
      vectors++;
      if ({gnt_valid_u, gnt_idx_u, gnt_u} !== exp) begin
        miscompares++;
        $display("FAIL unlimited_hold cyc=%0d got=%b want=%b", c, {gnt_valid_u, gnt_idx_u, gnt_u}, exp);
      end
    end
    req_u = 4'b1110;
    step();
    req_u = 4'b1111;
    step();
    exp = 7'b1_01_0010;
    vectors++;
    if ({gnt_valid_u, gnt_idx_u, gnt_u} !== exp) begin
      miscompares++;
      $display("FAIL unlimited_move got=%b want=%b", {gnt_valid_u, gnt_idx_u, gnt_u}, exp);
    end
    rst_u = 1'b1;
    step();
    exp = 7'b0_00_0000;
    vectors++;
    if ({gnt_valid_u, gnt_idx_u, gnt_u} !== exp) begin
      miscompares++;
      $display("FAIL midgrant_reset got=%b want=%b", {gnt_valid_u, gnt_idx_u, gnt_u}, exp);
    end
    rst_u = 1'b0;
    step();
    exp = 7'b1_00_0001;
    vectors++;
    if ({gnt_valid_u, gnt_idx_u, gnt_u} !== exp) begin
      miscompares++;
      $display("FAIL post_reset_owner0 got=%b want=%b", {gnt_valid_u, gnt_idx_u, gnt_u}, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    rst_u = 1'b1;
    req   = 4'b0000;
    req_u = 4'b0000;
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_handover();
    test_sole_timeout();
    test_unlimited_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
Round-robin arbiter that shares one decoder output vector among N = 2^IP_WIDTH requesters.
It registers a binary grant index and a grant-valid flag, then drives the existing decoder (en = gnt_valid, a = gnt_idx) to produce the one-hot grant bus.
Grants are held until the owner drops its request or a hold timeout expires; the next owner is then picked circularly after the last owner.

Parameters:
IP_WIDTH, 2, index width; N = 1<<IP_WIDTH requesters
MAX_HOLD, 16, maximum consecutive grant cycles per owner; 0 = unlimited

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  N  request vector, bit i = requester i
gnt  output  N  one-hot grant; decoder output, all-zero when gnt_valid=0
gnt_idx  output  IP_WIDTH  registered binary index of current owner
gnt_valid  output  1  registered; high while a grant is held

Behaviour:
- Reset (rst=1 at a clk edge): gnt_valid=0, gnt_idx=0, gnt=0, hold_cnt=0, last_ptr=N-1, state=IDLE. The first search after reset therefore starts at index 0. rst overrides every other event.
- States:
  - IDLE: no grant.
  - GRANT: gnt_valid=1, owner = gnt_idx.
- IDLE -> GRANT when req != 0. Winner = first set bit scanning last_ptr+1, last_ptr+2, ... mod N.
  - Latency: req seen at edge k gives gnt_idx/gnt_valid/gnt valid after edge k (one cycle).
  - gnt is combinational from the registered gnt_idx/gnt_valid only, never from req.
- In GRANT, hold_cnt increments each cycle. Release condition: req[gnt_idx]=0, OR (MAX_HOLD != 0 AND hold_cnt == MAX_HOLD-1). A timed-out grant therefore lasts exactly MAX_HOLD cycles.
- On release:
  - last_ptr <= gnt_idx.
  - Same-edge handover: if any other request is pending, the winner is picked by circular scan from gnt_idx+1. The new grant is visible the next cycle with no idle bubble.
  - Timeout with the owner as the sole requester: the owner is regranted, hold_cnt <= 0, and gnt remains continuously asserted.
  - Owner dropped and no other requests: -> IDLE, gnt=0 next cycle.
- Owner's req drop is observed at the same edge; gnt deasserts or moves one cycle after the drop.
- Requests from non-owners never preempt, except through timeout.
- hold_cnt width is clog2(MAX_HOLD+1), minimum 1. It is held at 0 when MAX_HOLD=0, and cleared on every new grant.
- Index arithmetic wraps modulo N (N-1 + 1 -> 0).
- req containing X/Z is not supported.

Decomposition:
- No shared package required. Derive N as a localparam from IP_WIDTH.
- Sub-module: the existing decoder, instantiated with IP_WIDTH passed through, en=gnt_valid, a=gnt_idx, op=gnt.
- Circular priority pick is a combinational function/always block inside this module (rotate req by last_ptr+1, priority encode, un-rotate).

Test Plan (IP_WIDTH=2, MAX_HOLD=4 unless stated):
1. Reset: hold rst 2 cycles with req=4'b1111 -> gnt=4'b0000, gnt_valid=0, gnt_idx=0 throughout. After release, first grant gnt=4'b0001 one cycle later.
2. Single requester: req=4'b0100 at edge k -> gnt_idx=2, gnt=4'b0100 after edge k. Drop req at edge m -> gnt=4'b0000, gnt_valid=0 after edge m.
3. Fair rotation: req=4'b1111 held 20 cycles -> owners 0,1,2,3,0, each exactly 4 cycles, no idle gap between owners.
4. Handover on drop: owner 1 granted, req changes 4'b1010 -> 4'b1000 -> next cycle gnt_idx=3, gnt=4'b1000. Requester 2 is skipped because it is not requesting.
5. Sole-requester timeout: req=4'b0001 for 10 cycles -> gnt=4'b0001 continuously, gnt_valid never drops, hold_cnt wraps 3->0.
6. Unlimited hold and mid-grant reset: MAX_HOLD=0, req=4'b1111 -> gnt stays 4'b0001 for 50 cycles. Then rst=1 for one cycle -> gnt=0. After rst falls, owner 0 is granted again (last_ptr reset to 3).
